// File: rtl/similarity_bundle_kernel.sv
// Streaming similarity kernel: accumulates popcount(A), popcount(B) and
// popcount(A&B) over an interleaved A0,B0,A1,B1,... hypervector word stream.
module similarity_bundle_kernel #(
  parameter int HV_DATA_WIDTH = 32,
  parameter int PC_WIDTH      = $clog2(HV_DATA_WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic                     first,
  input  logic                     last,
  input  logic [HV_DATA_WIDTH-1:0] data_in,
  output logic                     ready,
  output logic                     done,
  output logic [HV_DATA_WIDTH-1:0] AA_out,
  output logic [HV_DATA_WIDTH-1:0] BB_out,
  output logic [HV_DATA_WIDTH-1:0] AB_out,
  output logic                     err
);

  typedef enum logic [1:0] {S_IDLE, S_ACC_A, S_ACC_B, S_FLUSH} state_t;

  state_t                   state_q;
  logic                     done_q, err_q;
  logic                     s1_valid_q, s1_isa_q, s1_first_q;
  logic [HV_DATA_WIDTH-1:0] a_reg_q;
  logic [PC_WIDTH-1:0]      pc_a_q, pc_b_q, pc_ab_q;
  logic [HV_DATA_WIDTH-1:0] aa_q, bb_q, ab_q, aa_d, bb_d, ab_d;
  logic                     accept;

  function automatic logic [PC_WIDTH-1:0] popcnt(input logic [HV_DATA_WIDTH-1:0] v);
    logic [PC_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < HV_DATA_WIDTH; i++) c = c + PC_WIDTH'(v[i]);
    return c;
  endfunction

  assign ready  = (state_q != S_FLUSH);
  assign accept = valid && ready;

  // Control FSM plus stage 1; the state itself encodes the A/B phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b1;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_isa_q   <= 1'b0;
      s1_first_q <= 1'b0;
      a_reg_q    <= '0;
      pc_a_q     <= '0;
      pc_b_q     <= '0;
      pc_ab_q    <= '0;
    end else begin
      s1_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // done re-asserts on the first idle edge after a flush, so it
          // trails the final accumulate by one cycle.
          done_q <= !(accept && first);
          if (accept) begin
            if (first) begin
              err_q      <= last;
              state_q    <= S_ACC_B;
              s1_valid_q <= 1'b1;
              s1_isa_q   <= 1'b1;
              s1_first_q <= 1'b1;
              a_reg_q    <= data_in;
              pc_a_q     <= popcnt(data_in);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ACC_A: begin
          if (accept) begin
            if (first || last) err_q <= 1'b1;
            state_q    <= S_ACC_B;
            s1_valid_q <= 1'b1;
            s1_isa_q   <= 1'b1;
            s1_first_q <= first;
            a_reg_q    <= data_in;
            pc_a_q     <= popcnt(data_in);
          end
        end
        S_ACC_B: begin
          if (accept) begin
            s1_valid_q <= 1'b1;
            if (first) begin
              err_q      <= 1'b1;
              state_q    <= S_ACC_B;
              s1_isa_q   <= 1'b1;
              s1_first_q <= 1'b1;
              a_reg_q    <= data_in;
              pc_a_q     <= popcnt(data_in);
            end else begin
              state_q    <= last ? S_FLUSH : S_ACC_A;
              s1_isa_q   <= 1'b0;
              s1_first_q <= 1'b0;
              pc_b_q     <= popcnt(data_in);
              pc_ab_q    <= popcnt(a_reg_q & data_in);
            end
          end
        end
        S_FLUSH: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    aa_d = aa_q;
    bb_d = bb_q;
    ab_d = ab_q;
    if (s1_valid_q) begin
      if (s1_isa_q && s1_first_q) begin
        aa_d = HV_DATA_WIDTH'(pc_a_q);
        bb_d = '0;
        ab_d = '0;
      end else if (s1_isa_q) begin
        aa_d = aa_q + HV_DATA_WIDTH'(pc_a_q);
      end else begin
        bb_d = bb_q + HV_DATA_WIDTH'(pc_b_q);
        ab_d = ab_q + HV_DATA_WIDTH'(pc_ab_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aa_q <= '0;
      bb_q <= '0;
      ab_q <= '0;
    end else begin
      aa_q <= aa_d;
      bb_q <= bb_d;
      ab_q <= ab_d;
    end
  end

  assign done   = done_q;
  assign err    = err_q;
  assign AA_out = aa_q;
  assign BB_out = bb_q;
  assign AB_out = ab_q;

endmodule

// File: doc/similarity_bundle_kernel.md
Name: similarity_bundle_kernel

Overview:
- Streaming similarity kernel that sits directly downstream of the similarity direct mapper.
- Consumes an interleaved word stream A0,B0,A1,B1,…; each word is a packed slice of a binary hypervector.
- Accumulates three scalars over the whole vector pair:
  - AA = Σpopcount(A)
  - BB = Σpopcount(B)
  - AB = Σpopcount(A&B)
- Results feed the downstream cosine/Jaccard scoring. The kernel signals completion back to the mapper.

Parameters:
- HV_DATA_WIDTH, 32: width of each stream word and of each accumulator/output.
- PC_WIDTH, $clog2(HV_DATA_WIDTH)+1: width of the per-word popcount registers.

Ports:
- clk  input  1  single clock; all flops on rising edge.
- reset  input  1  asynchronous, active-high reset. Clears all state immediately.
- valid  input  1  data_in carries a beat this cycle.
- first  input  1  beat is A0, the first word of a new vector pair.
- last  input  1  beat is the final B word of the pair.
- data_in  input  HV_DATA_WIDTH  stream word.
- ready  output  1  kernel can accept a beat this cycle.
- done  output  1  level signal; accumulator outputs are final and stable.
- AA_out  output  HV_DATA_WIDTH  accumulated popcount(A).
- BB_out  output  HV_DATA_WIDTH  accumulated popcount(B).
- AB_out  output  HV_DATA_WIDTH  accumulated popcount(A&B).
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset values:
  - state=S_IDLE, ready=1, done=1.
  - AA_out=BB_out=AB_out=0, err=0.
  - phase=A; all pipeline valid bits=0; a_reg=0.
- Beat acceptance: a beat is accepted when valid&ready at a rising edge. valid while ready=0 is ignored; no beat is lost from the kernel side.
- Phase bit alternates A→B on each accepted beat, except as overridden by the first/last rules below.
- States:
  - S_IDLE: ready=1.
    - Accepted beat with first=1: clear err, done<=0, go to S_ACC_B.
    - Accepted beat with first=0: discard it, set err, stay in S_IDLE.
  - S_ACC_A: ready=1; expecting an A word.
    - Accepted beat: go to S_ACC_B.
    - last=1 on an A beat: set err and ignore last.
  - S_ACC_B: ready=1; expecting a B word.
    - Accepted beat with last=1: go to S_FLUSH.
    - Accepted beat with last=0: go to S_ACC_A.
  - S_FLUSH: ready=0 for exactly one cycle, then S_IDLE with done<=1.
- Pipeline, stage 1 (registered on the acceptance edge):
  - A beat: a_reg<=data_in; pc_a<=popcount(data_in).
  - B beat: pc_b<=popcount(data_in); pc_ab<=popcount(a_reg&data_in).
  - Flags s1_valid, s1_isA, s1_first, s1_last are carried with the data.
- Pipeline, stage 2 (one edge later):
  - A entry: AA += pc_a. If s1_first, AA <= pc_a (no add), and BB and AB <= 0.
  - B entry: BB += pc_b; AB += pc_ab.
  - Popcounts are zero-extended to HV_DATA_WIDTH. Accumulators wrap modulo 2^HV_DATA_WIDTH; there is no saturation.
- Latency:
  - Last B accepted at edge T → stage 1 at T, final accumulate at T+1, done=1 visible after T+2 (S_FLUSH→S_IDLE edge).
  - Outputs are final and unchanged from T+1 onward.
- Output holding: outputs hold their previous values while done=1, until the next first beat's stage-2 update (edge T0+1) overwrites them.
- first=1 in S_ACC_A or S_ACC_B (mid-vector restart):
  - Set err; the beat is treated as a new A0.
  - The accumulators restart via the s1_first path; phase=A; state goes to S_ACC_B.
- Simultaneous first&last on one beat: first wins and last is ignored; err is set because last appears on an A word.
- Reset mid-operation: all state clears asynchronously, and any partial sums are discarded. After reset deasserts, the next accepted beat must carry first.
- ready is a pure function of state (no combinational path from valid). This is compatible with an upstream that gates its valid with ready.

Test Plan:
- Single pair, W=32, A=FFFF_FFFF with first, B=0000_FFFF with last → AA=32, BB=16, AB=16; done rises two edges after the B accept; ready low for one cycle.
- Four pairs back-to-back: A words {0x1,0x3,0x7,0xF}, each B=0xF (last on the fourth B) → AA=10, BB=16, AB=10, err=0.
- Idle gaps of random length between every beat, same data as the previous case → identical results; done stays 0 throughout until final.
- Abort mid-vector: after A0=0xFF, B0=0xFF, send first with A=0x1, then B=0x1 with last → AA=1, BB=1, AB=1, err=1; err clears on the next clean first.
- last on an A beat (A=0xF, first+last), then B=0xF with last → err=1; done only after the B beat; AA=4, BB=4, AB=4.
- Assert reset mid-stream after two beats → outputs 0, done=1, ready=1 immediately. A beat without first in S_IDLE → discarded, err=1, outputs still 0.
